// File: rtl/text_banner_ctrl.sv
// Banner text controller: picks the glyph slot for each pixel, animates slide-in and blink,
// and gates the renderer's glyph bit into a registered text_on two clocks after x/y.
module text_banner_ctrl #(
  parameter int ORIGIN_X     = 200,
  parameter int ORIGIN_Y     = 230,
  parameter int PITCH        = 16,
  parameter int SLIDE_START  = 600,
  parameter int SLIDE_STEP   = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        frame_tick,
  input  logic        show,
  input  logic        blink_en,
  input  logic [1:0]  msg_sel,
  input  logic        glyph_char,
  output logic [9:0]  glyph_x,
  output logic [9:0]  glyph_y,
  output logic [31:0] posx,
  output logic [31:0] posy,
  output logic [4:0]  select_char,
  output logic        text_on,
  output logic        busy
);

  localparam int PSH = $clog2(PITCH);
  localparam int CW  = $clog2(BLINK_FRAMES);
  localparam logic [9:0]    OX       = 10'(ORIGIN_X);
  localparam logic [9:0]    OY       = 10'(ORIGIN_Y);
  localparam logic [9:0]    OY_END   = 10'(ORIGIN_Y + 19);
  localparam logic [9:0]    START    = 10'(SLIDE_START);
  localparam logic [9:0]    ENTRY    = 10'(SLIDE_START - SLIDE_STEP);
  localparam logic [9:0]    CLAMP_AT = 10'(ORIGIN_X + SLIDE_STEP);
  localparam logic [9:0]    STEP     = 10'(SLIDE_STEP);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);
  localparam logic [4:0]    BLANK    = 5'd31;

  typedef enum logic [1:0] {IDLE, SLIDE, HOLD} state_t;

  state_t        state, state_nx;
  logic [9:0]    origin, origin_nx;
  logic [1:0]    msg_latch, msg_nx;
  logic [CW-1:0] blink_cnt, blink_nx;
  logic          phase_on, phase_nx;

  function automatic logic [2:0] msg_len(input logic [1:0] m);
    case (m)
      2'd0:    return 3'd5;
      2'd1:    return 3'd2;
      2'd2:    return 3'd3;
      default: return 3'd5;
    endcase
  endfunction

  function automatic logic [4:0] msg_code(input logic [1:0] m, input logic [2:0] i);
    logic [4:0] c;
    c = BLANK;
    case (m)
      2'd0: case (i)
        3'd0: c = 5'd0; 3'd1: c = 5'd1; 3'd2: c = 5'd4; 3'd3: c = 5'd2; 3'd4: c = 5'd1;
        default: c = BLANK;
      endcase
      2'd1: case (i)
        3'd0: c = 5'd3; 3'd1: c = 5'd8;
        default: c = BLANK;
      endcase
      2'd2: case (i)
        3'd0: c = 5'd6; 3'd1: c = 5'd7; 3'd2: c = 5'd1;
        default: c = BLANK;
      endcase
      default: case (i)
        3'd0: c = 5'd2; 3'd1: c = 5'd7; 3'd2: c = 5'd3; 3'd3: c = 5'd6; 3'd4: c = 5'd1;
        default: c = BLANK;
      endcase
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      origin    <= START;
      msg_latch <= '0;
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else begin
      state     <= state_nx;
      origin    <= origin_nx;
      msg_latch <= msg_nx;
      blink_cnt <= blink_nx;
      phase_on  <= phase_nx;
    end
  end

  // Entering SLIDE already takes the first step, so the first frame after a start shows SLIDE_START-SLIDE_STEP.
  always_comb begin
    state_nx  = state;
    origin_nx = origin;
    msg_nx    = msg_latch;
    blink_nx  = blink_cnt;
    phase_nx  = phase_on;
    if (frame_tick) begin
      if (state != IDLE && !show) begin
        state_nx  = IDLE;
        origin_nx = START;
      end else begin
        case (state)
          IDLE: if (show) begin
            state_nx  = SLIDE;
            msg_nx    = msg_sel;
            origin_nx = ENTRY;
          end
          SLIDE, HOLD: begin
            if (msg_sel != msg_latch) begin
              state_nx  = SLIDE;
              msg_nx    = msg_sel;
              origin_nx = ENTRY;
            end else if (state == SLIDE) begin
              if (origin <= CLAMP_AT) begin
                origin_nx = OX;
                state_nx  = HOLD;
              end else begin
                origin_nx = origin - STEP;
              end
            end else if (blink_en) begin
              if (blink_cnt == CNT_LAST) begin
                blink_nx = '0;
                phase_nx = ~phase_on;
              end else begin
                blink_nx = blink_cnt + 1'b1;
              end
            end else begin
              blink_nx = '0;
              phase_nx = 1'b1;
            end
          end
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    busy = (state == SLIDE);
  end

  logic signed [10:0] dx;
  logic [10-PSH:0]    slot;
  logic [10:0]        slot_base;
  logic [10:0]        slot_left;
  logic               valid, inbox, inbox_q;

  always_comb begin
    dx        = $signed({1'b0, x} - {1'b0, origin});
    slot      = dx[10:PSH];
    slot_base = {dx[10:PSH], {PSH{1'b0}}};
    slot_left = dx[10] ? {1'b0, origin} : ({1'b0, origin} + slot_base);
    valid     = !dx[10] && (slot < (11-PSH)'(msg_len(msg_latch))) && (state != IDLE);
    inbox     = valid && (dx[PSH-1:0] <= PSH'(9)) && (y >= OY) && (y <= OY_END)
                && video_on && phase_on;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glyph_x     <= '0;
      glyph_y     <= '0;
      posx        <= '0;
      select_char <= BLANK;
      inbox_q     <= 1'b0;
      text_on     <= 1'b0;
    end else begin
      glyph_x     <= x;
      glyph_y     <= y;
      posx        <= 32'(slot_left);
      select_char <= valid ? msg_code(msg_latch, slot[2:0]) : BLANK;
      inbox_q     <= inbox;
      text_on     <= inbox_q & glyph_char;
    end
  end

  assign posy = 32'(ORIGIN_Y);

endmodule

// File: tb/tb_text_banner_ctrl.sv
// Directed-plus-random bench for text_banner_ctrl against a frame-level reference model.
module tb_text_banner_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  x = '0, y = '0;
  logic        video_on = 1'b0, frame_tick = 1'b0, show = 1'b0, blink_en = 1'b0;
  logic [1:0]  msg_sel = '0;
  logic        glyph_char = 1'b0;
  logic [9:0]  glyph_x, glyph_y;
  logic [31:0] posx, posy;
  logic [4:0]  select_char;
  logic        text_on, busy;

  text_banner_ctrl #(
    .ORIGIN_X(200), .ORIGIN_Y(230), .PITCH(16),
    .SLIDE_START(600), .SLIDE_STEP(8), .BLINK_FRAMES(30)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on), .frame_tick(frame_tick),
    .show(show), .blink_en(blink_en), .msg_sel(msg_sel), .glyph_char(glyph_char),
    .glyph_x(glyph_x), .glyph_y(glyph_y), .posx(posx), .posy(posy),
    .select_char(select_char), .text_on(text_on), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int CODES [4][5] = '{'{0, 1, 4, 2, 1}, '{3, 8, 31, 31, 31}, '{6, 7, 1, 31, 31}, '{2, 7, 3, 6, 1}};
  int LEN   [4]    = '{5, 2, 3, 5};

  // Frame-level reference: banner visible/sliding flags, left edge, message, blink frame count.
  bit m_active, m_sliding;
  int m_origin, m_msg, m_blink;
  bit prev_ok;
  bit prev_inbox;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_sc(input int xv);
    int dx;
    if (!m_active) return 31;
    dx = xv - m_origin;
    if (dx < 0) return 31;
    if (dx / 16 >= LEN[m_msg]) return 31;
    return CODES[m_msg][dx / 16];
  endfunction

  function automatic int m_posx(input int xv);
    return m_origin + ((xv - m_origin) / 16) * 16;
  endfunction

  function automatic bit m_inbox(input int xv, input int yv, input bit vo);
    bit phase;
    phase = ((m_blink / 30) % 2) == 0;
    if (m_sc(xv) == 31) return 1'b0;
    return (((xv - m_origin) % 16) <= 9) && yv >= 230 && yv <= 249 && vo && phase;
  endfunction

  task automatic model_reset();
    m_active = 0; m_sliding = 0; m_origin = 600; m_msg = 0; m_blink = 0; prev_ok = 0;
  endtask

  task automatic model_tick();
    if (!m_active) begin
      if (show) begin
        m_active = 1; m_sliding = 1; m_msg = int'(msg_sel); m_origin = 592;
      end
    end else if (!show) begin
      m_active = 0; m_sliding = 0; m_origin = 600;
    end else if (int'(msg_sel) != m_msg) begin
      m_msg = int'(msg_sel); m_origin = 592; m_sliding = 1;
    end else if (m_sliding) begin
      m_origin = (m_origin - 8 > 200) ? m_origin - 8 : 200;
      if (m_origin == 200) m_sliding = 0;
    end else begin
      m_blink = blink_en ? m_blink + 1 : 0;
    end
  endtask

  task automatic cycle(input int xv, input int yv, input bit vo, input bit g);
    int exp_sc;
    @(negedge clk);
    x = 10'(xv); y = 10'(yv); video_on = vo; glyph_char = g;
    @(posedge clk); #1;
    exp_sc = m_sc(xv);
    chk("select_char", 32'(select_char), exp_sc);
    chk("glyph_x", 32'(glyph_x), xv);
    chk("glyph_y", 32'(glyph_y), yv);
    if (exp_sc != 31) chk("posx", posx, m_posx(xv));
    if (prev_ok) chk("text_on", 32'(text_on), 32'(prev_inbox & g));
    prev_inbox = m_inbox(xv, yv, vo);
    prev_ok = 1;
  endtask

  task automatic probe(input int xv, input int yv, input bit vo, input bit g);
    cycle(xv, yv, vo, g);
    cycle(xv, yv, vo, g);
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    model_tick();
    frame_tick = 1'b0;
    prev_ok = 0;
    chk("busy", 32'(busy), 32'(m_active && m_sliding));
  endtask

  task automatic rand_pixels(input int n);
    int rx;
    repeat (n) begin
      rx = m_origin - 8 + int'($urandom_range(0, 95));
      if ($urandom_range(0, 7) == 0) rx = int'($urandom_range(0, 1023));
      if (rx < 0) rx = 0;
      if (rx > 1023) rx = 1023;
      cycle(rx, 226 + int'($urandom_range(0, 27)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_glyph_x", 32'(glyph_x), 0);
    chk("rst_glyph_y", 32'(glyph_y), 0);
    chk("rst_posx", posx, 0);
    chk("rst_posy", posy, 230);
    chk("rst_select_char", 32'(select_char), 31);
    chk("rst_text_on", 32'(text_on), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;

    rand_pixels(6);
    show = 1'b1; msg_sel = 2'd0;
    tick();
    chk("slide_busy", 32'(busy), 1);
    probe(592, 240, 1'b1, 1'b1);
    chk("slide_first_posx", posx, 592);
    cycle(591, 240, 1'b1, 1'b1);
    rand_pixels(10);

    for (int i = 2; i <= 50; i++) begin
      tick();
      rand_pixels(3);
    end
    chk("hold_busy", 32'(busy), 0);
    probe(200, 240, 1'b1, 1'b0);
    chk("hold_posx0", posx, 200);
    chk("hold_sc0", 32'(select_char), 0);

    for (int xv = 200; xv <= 279; xv++) cycle(xv, 230, 1'b1, 1'($urandom_range(0, 1)));
    for (int xv = 210; xv <= 215; xv++) cycle(xv, 230, 1'b1, 1'b1);
    cycle(216, 230, 1'b1, 1'b1);
    chk("gap_text_on", 32'(text_on), 0);

    probe(201, 229, 1'b1, 1'b1); chk("y229_text_on", 32'(text_on), 0);
    probe(201, 250, 1'b1, 1'b1); chk("y250_text_on", 32'(text_on), 0);
    probe(201, 240, 1'b1, 1'b1); chk("y240_text_on", 32'(text_on), 1);
    probe(201, 240, 1'b0, 1'b1); chk("vo0_text_on", 32'(text_on), 0);

    blink_en = 1'b1;
    for (int i = 1; i <= 95; i++) begin
      tick();
      probe(201, 240, 1'b1, 1'b1);
      if (i == 29 || i == 60) chk("blink_on", 32'(text_on), 1);
      if (i == 30 || i == 59 || i == 90) chk("blink_off", 32'(text_on), 0);
    end
    blink_en = 1'b0;
    tick();
    probe(201, 240, 1'b1, 1'b1);
    chk("blink_dis_on", 32'(text_on), 1);

    msg_sel = 2'd2;
    probe(201, 240, 1'b1, 1'b1);
    chk("msg_wait_sc", 32'(select_char), 0);
    tick();
    chk("relatch_busy", 32'(busy), 1);
    probe(592, 240, 1'b1, 1'b1); chk("hit_sc0", 32'(select_char), 6);
    cycle(639, 240, 1'b1, 1'b1); chk("hit_sc2", 32'(select_char), 1);
    cycle(640, 240, 1'b1, 1'b1); chk("hit_past_end", 32'(select_char), 31);
    rand_pixels(12);
    tick();
    rand_pixels(8);

    show = 1'b0; msg_sel = 2'd3;
    tick();
    chk("idle_busy", 32'(busy), 0);
    probe(592, 240, 1'b1, 1'b1); chk("idle_sc", 32'(select_char), 31);

    show = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      rand_pixels(2);
    end
    probe(201, 240, 1'b1, 1'b1);
    chk("right_sc0", 32'(select_char), 2);
    chk("pre_reset_text_on", 32'(text_on), 1);

    #2 reset = 1'b1;
    #1;
    chk("async_text_on", 32'(text_on), 0);
    chk("async_sc", 32'(select_char), 31);
    chk("async_busy", 32'(busy), 0);
    chk("async_posx", posx, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("reshow_busy", 32'(busy), 1);
    rand_pixels(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
